// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Resolutions are popped from the head
// and turned into one-cycle training updates. A misprediction squashes every younger entry.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      alloc_v_i,
  input  logic [PC_W-1:0]           alloc_pc_i,
  input  logic                      alloc_pred_local_i,
  input  logic                      alloc_pred_global_i,
  input  logic                      alloc_pred_final_i,
  output logic                      alloc_ready_o,
  input  logic                      resolve_v_i,
  input  logic                      resolve_taken_i,
  input  logic                      flush_i,
  output logic                      upd_v_o,
  output logic [PC_W-1:0]           upd_pc_o,
  output logic                      upd_taken_o,
  output logic                      upd_local_ok_o,
  output logic                      upd_global_ok_o,
  output logic                      mispredict_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [CNT_W-1:0]          misp_cnt_o,
  output logic                      err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic             loc_mem [DEPTH];
  logic             glb_mem [DEPTH];
  logic             fin_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             alloc_ok;
  logic             res_ok;
  logic             misp;

  assign count_o       = count;
  assign alloc_ready_o = (count < DEPTH_C);
  assign alloc_ok      = alloc_v_i & alloc_ready_o;
  assign res_ok        = resolve_v_i & (count != '0);
  assign misp          = res_ok & (fin_mem[rd_ptr] != resolve_taken_i);

  // Storage is never reset; only slots between rd_ptr and wr_ptr are meaningful.
  always_ff @(posedge clk_i) begin
    if (alloc_ok && !reset_i && !flush_i && !misp) begin
      pc_mem[wr_ptr]  <= alloc_pc_i;
      loc_mem[wr_ptr] <= alloc_pred_local_i;
      glb_mem[wr_ptr] <= alloc_pred_global_i;
      fin_mem[wr_ptr] <= alloc_pred_final_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      upd_v_o         <= 1'b0;
      upd_pc_o        <= '0;
      upd_taken_o     <= 1'b0;
      upd_local_ok_o  <= 1'b0;
      upd_global_ok_o <= 1'b0;
      mispredict_o    <= 1'b0;
      misp_cnt_o      <= '0;
      err_o           <= 1'b0;
    end else begin
      upd_v_o      <= 1'b0;
      mispredict_o <= 1'b0;
      if (flush_i) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if ((alloc_v_i && !alloc_ready_o) || (resolve_v_i && count == '0)) begin
          err_o <= 1'b1;
        end
        if (res_ok) begin
          upd_v_o         <= 1'b1;
          upd_pc_o        <= pc_mem[rd_ptr];
          upd_taken_o     <= resolve_taken_i;
          upd_local_ok_o  <= (loc_mem[rd_ptr] == resolve_taken_i);
          upd_global_ok_o <= (glb_mem[rd_ptr] == resolve_taken_i);
          mispredict_o    <= misp;
          rd_ptr          <= rd_ptr + PTR_W'(1);
        end
        // A wrong head squashes everything younger, including this cycle's allocation.
        if (misp) begin
          wr_ptr <= rd_ptr + PTR_W'(1);
          count  <= '0;
          if (misp_cnt_o != '1) begin
            misp_cnt_o <= misp_cnt_o + CNT_W'(1);
          end
        end else begin
          if (alloc_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (alloc_ok && !res_ok) begin
            count <= count + CW'(1);
          end else if (!alloc_ok && res_ok) begin
            count <= count - CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench: stimulus pushes hand-computed updates into a scoreboard queue,
// a negedge monitor pops and compares whenever the queue presents an update.
module tb_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        alloc_v_i = 1'b0;
  logic [31:0] alloc_pc_i = '0;
  logic        alloc_pred_local_i = 1'b0;
  logic        alloc_pred_global_i = 1'b0;
  logic        alloc_pred_final_i = 1'b0;
  logic        alloc_ready_o;
  logic        resolve_v_i = 1'b0;
  logic        resolve_taken_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        upd_v_o;
  logic [31:0] upd_pc_o;
  logic        upd_taken_o;
  logic        upd_local_ok_o;
  logic        upd_global_ok_o;
  logic        mispredict_o;
  logic [3:0]  count_o;
  logic [15:0] misp_cnt_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        lok;
    logic        gok;
    logic        misp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_resolve_queue #(.DEPTH(8), .PC_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_pc_i(alloc_pc_i),
    .alloc_pred_local_i(alloc_pred_local_i), .alloc_pred_global_i(alloc_pred_global_i),
    .alloc_pred_final_i(alloc_pred_final_i), .alloc_ready_o(alloc_ready_o),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i), .flush_i(flush_i),
    .upd_v_o(upd_v_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
    .upd_local_ok_o(upd_local_ok_o), .upd_global_ok_o(upd_global_ok_o),
    .mispredict_o(mispredict_o), .count_o(count_o), .misp_cnt_o(misp_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (upd_v_o === 1'b1) begin
      checks++;
      got = '{upd_pc_o, upd_taken_o, upd_local_ok_o, upd_global_ok_o, mispredict_o};
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_update got pc=%h taken=%b lok=%b gok=%b misp=%b, required none",
                 upd_pc_o, upd_taken_o, upd_local_ok_o, upd_global_ok_o, mispredict_o);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL update got pc=%h taken=%b lok=%b gok=%b misp=%b, required pc=%h taken=%b lok=%b gok=%b misp=%b",
                   got.pc, got.taken, got.lok, got.gok, got.misp,
                   want.pc, want.taken, want.lok, want.gok, want.misp);
        end
      end
    end else if (reset_i === 1'b0) begin
      checks++;
      if (upd_v_o !== 1'b0 || mispredict_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_pulse got upd_v=%b misp=%b, required 0 0", upd_v_o, mispredict_o);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic [31:0] pc, input logic pl, input logic pg,
                                input logic pf, input logic r, input logic t, input logic f,
                                input logic rst);
    alloc_v_i = a; alloc_pc_i = pc;
    alloc_pred_local_i = pl; alloc_pred_global_i = pg; alloc_pred_final_i = pf;
    resolve_v_i = r; resolve_taken_i = t; flush_i = f; reset_i = rst;
    @(posedge clk);
    #1;
    alloc_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pl, input logic pg, input logic pf);
    apply_stimulus(1'b1, pc, pl, pg, pf, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve_expect(input logic t, input logic [31:0] pc, input logic lok,
                                input logic gok, input logic misp);
    exp_q.push_back('{pc, t, lok, gok, misp});
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0);
  endtask

  initial begin
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("reset_count", 32'(count_o), 0);
    check_output("reset_err", 32'(err_o), 0);
    check_output("reset_misp_cnt", 32'(misp_cnt_o), 0);
    check_output("reset_ready", 32'(alloc_ready_o), 1);
    check_output("reset_upd_pc", upd_pc_o, 0);

    // Three correctly predicted branches drain in order.
    alloc(32'h10, 1, 1, 1);
    alloc(32'h20, 1, 1, 1);
    alloc(32'h30, 1, 1, 1);
    check_output("three_count", 32'(count_o), 3);
    resolve_expect(1, 32'h10, 1, 1, 0);
    resolve_expect(1, 32'h20, 1, 1, 0);
    resolve_expect(1, 32'h30, 1, 1, 0);
    check_output("drain_count", 32'(count_o), 0);

    // Fill, overflow, then simultaneous alloc+resolve while full.
    for (int i = 0; i < 8; i++) begin
      alloc(32'h100 + 32'(4 * i), i[0], i[1], 1'b1);
    end
    check_output("full_count", 32'(count_o), 8);
    check_output("full_ready", 32'(alloc_ready_o), 0);
    check_output("full_err_before", 32'(err_o), 0);
    alloc(32'h1F0, 1, 1, 1);
    check_output("overflow_count", 32'(count_o), 8);
    check_output("overflow_err", 32'(err_o), 1);
    exp_q.push_back('{32'h100, 1'b1, 1'b0, 1'b0, 1'b0});
    apply_stimulus(1'b1, 32'h1F4, 1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("full_alloc_resolve_count", 32'(count_o), 7);

    // Reset wins over everything driven in the same cycle.
    apply_stimulus(1'b1, 32'h1F8, 1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_output("reset2_count", 32'(count_o), 0);
    check_output("reset2_err", 32'(err_o), 0);
    check_output("reset2_ready", 32'(alloc_ready_o), 1);

    // Misprediction at the head squashes the younger entries.
    for (int i = 0; i < 4; i++) begin
      alloc(32'h200 + 32'(4 * i), 1, 0, 1);
    end
    check_output("four_count", 32'(count_o), 4);
    resolve_expect(0, 32'h200, 0, 1, 1);
    check_output("misp_count", 32'(count_o), 0);
    check_output("misp_cnt_1", 32'(misp_cnt_o), 1);
    check_output("misp_err", 32'(err_o), 0);

    alloc(32'h300, 0, 0, 0);
    alloc(32'h304, 0, 0, 0);
    exp_q.push_back('{32'h300, 1'b1, 1'b0, 1'b0, 1'b1});
    apply_stimulus(1'b1, 32'h308, 1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("misp_alloc_count", 32'(count_o), 0);
    check_output("misp_cnt_2", 32'(misp_cnt_o), 2);

    // Flush beats a same-cycle resolve and leaves err alone.
    alloc(32'h500, 1, 1, 1);
    alloc(32'h504, 1, 1, 1);
    apply_stimulus(1'b0, '0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_output("flush_count", 32'(count_o), 0);
    check_output("flush_err", 32'(err_o), 0);
    alloc(32'h600, 1, 1, 0);
    resolve_expect(0, 32'h600, 0, 0, 0);
    check_output("post_flush_count", 32'(count_o), 0);

    // Twenty alloc/resolve pairs at occupancy one walk the pointers round twice.
    alloc(32'h400, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back('{32'h400 + 32'(4 * i), 1'b1, i[0], 1'b1, 1'b0});
      apply_stimulus(1'b1, 32'h404 + 32'(4 * i), ~i[0], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check_output("wrap_count", 32'(count_o), 1);
    check_output("wrap_err", 32'(err_o), 0);
    resolve_expect(1, 32'h450, 0, 1, 0);
    check_output("wrap_drain_count", 32'(count_o), 0);
    check_output("wrap_misp_cnt", 32'(misp_cnt_o), 2);

    apply_stimulus(1'b0, '0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("empty_resolve_err", 32'(err_o), 1);
    check_output("empty_resolve_count", 32'(count_o), 0);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
